// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates five sound requesters onto one note output,
// playing fixed ROM sequences with cycle-counted note and gap timing.
module sound_sequencer #(
  parameter int unsigned NOTE_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       reqStart,
  input  logic       reqEnd,
  input  logic       reqHit,
  input  logic       reqLrrr,
  input  logic       reqShot,
  input  logic       mute,
  output logic [3:0] sndOut,
  output logic       busy,
  output logic [2:0] curId
);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  id_q, id_nx;
  logic [2:0]  idx_q, idx_nx;
  logic [31:0] cnt_q, cnt_nx;
  logic [5:1]  pend_q, pend_nx;
  logic [5:1]  req, req_m, cand;
  logic [2:0]  win, end_win;
  logic        note_done, gap_done, seq_end;

  function automatic logic [2:0] top(input logic [5:1] v);
    top = 3'd0;
    for (int i = 5; i >= 1; i--)
      if (v[i]) top = 3'(i);
  endfunction

  function automatic logic [5:1] onehot(input logic [2:0] id);
    onehot = '0;
    for (int i = 1; i <= 5; i++)
      if (id == 3'(i)) onehot[i] = 1'b1;
  endfunction

  function automatic logic [2:0] last(input logic [2:0] id);
    case (id)
      3'd1, 3'd2: last = 3'd7;
      3'd3:       last = 3'd2;
      3'd4:       last = 3'd3;
      3'd5:       last = 3'd1;
      default:    last = 3'd0;
    endcase
  endfunction

  // Each sequence packed as nibbles, note 0 in the low nibble.
  function automatic logic [3:0] rom(
    input logic [2:0] id,
    input logic [2:0] idx
  );
    logic [31:0] s;
    case (id)
      3'd1:    s = 32'h7599_3277;
      3'd2:    s = 32'h1112_3579;
      3'd3:    s = 32'h0000_0BCD;
      3'd4:    s = 32'h0000_FEFE;
      3'd5:    s = 32'h0000_00AB;
      default: s = 32'h0;
    endcase
    rom = s[{idx, 2'b00} +: 4];
  endfunction

  assign req = {reqShot, reqLrrr, reqHit, reqEnd, reqStart};
  // A request for the sequence already playing is ignored outright.
  assign req_m     = req & ~onehot(id_q);
  assign cand      = pend_q | req_m;
  assign win       = top(req_m);
  assign end_win   = top(cand);
  assign note_done = (state == NOTE) && (cnt_q == NOTE_CYCLES - 1);
  assign gap_done  = (state == GAP) && (cnt_q == GAP_CYCLES - 1);
  assign seq_end   = gap_done && (idx_q == last(id_q));

  always_comb begin
    state_nx = state;
    id_nx    = id_q;
    idx_nx   = idx_q;
    cnt_nx   = cnt_q + 32'd1;
    pend_nx  = pend_q;
    if (state == IDLE) begin
      cnt_nx = '0;
      if (win != 3'd0) begin
        state_nx = NOTE;
        id_nx    = win;
        idx_nx   = '0;
        pend_nx  = pend_q | (req_m & ~onehot(win));
      end
    end else if (seq_end) begin
      cnt_nx   = '0;
      idx_nx   = '0;
      id_nx    = end_win;
      pend_nx  = cand & ~onehot(end_win);
      state_nx = (end_win != 3'd0) ? NOTE : IDLE;
    end else if (win != 3'd0 && win < id_q) begin
      state_nx = NOTE;
      id_nx    = win;
      idx_nx   = '0;
      cnt_nx   = '0;
      pend_nx  = pend_q | (req_m & ~onehot(win));
    end else begin
      pend_nx = pend_q | req_m;
      if (note_done) begin
        state_nx = GAP;
        cnt_nx   = '0;
      end else if (gap_done) begin
        state_nx = NOTE;
        cnt_nx   = '0;
        idx_nx   = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      id_q   <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      state  <= state_nx;
      id_q   <= id_nx;
      idx_q  <= idx_nx;
      cnt_q  <= cnt_nx;
      pend_q <= pend_nx;
    end
  end

  assign busy   = (state != IDLE);
  assign curId  = id_q;
  assign sndOut = (state == NOTE && !mute) ? rom(id_q, idx_q) : 4'd0;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: randomized and directed checks of sound_sequencer
// against a time-based reference model of the note schedule.
module tb_sound_sequencer;

  localparam int N = 4;
  localparam int G = 2;
  localparam int P = N + G;

  logic       clk = 1'b0;
  logic       resetN;
  logic [5:1] rq;
  logic       mute;
  logic [3:0] sndOut;
  logic       busy;
  logic [2:0] curId;

  int checks = 0;
  int failures = 0;

  int notes [1:5][8] = '{
    '{7, 7, 2, 3, 9, 9, 5, 7},
    '{9, 7, 5, 3, 2, 1, 1, 1},
    '{13, 12, 11, 0, 0, 0, 0, 0},
    '{14, 15, 14, 15, 0, 0, 0, 0},
    '{11, 10, 0, 0, 0, 0, 0, 0}
  };
  int lens [1:5] = '{8, 8, 3, 4, 2};

  int      m_id;
  int      m_t;
  bit [5:1] m_pend;

  sound_sequencer #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
    .clk(clk),
    .resetN(resetN),
    .reqStart(rq[1]),
    .reqEnd(rq[2]),
    .reqHit(rq[3]),
    .reqLrrr(rq[4]),
    .reqShot(rq[5]),
    .mute(mute),
    .sndOut(sndOut),
    .busy(busy),
    .curId(curId)
  );

  always #5 clk = ~clk;

  function automatic int top(bit [5:1] v);
    for (int i = 1; i <= 5; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] exp_snd();
    if (m_id == 0 || mute) return 4'd0;
    if ((m_t % P) >= N) return 4'd0;
    return 4'(notes[m_id][m_t / P]);
  endfunction

  function automatic logic [7:0] exp_all();
    return {(m_id != 0), 3'(m_id), exp_snd()};
  endfunction

  // Reference: a sequence is a start time plus elapsed cycles; it ends
  // when len*(N+G) cycles have elapsed.
  task automatic model_edge(bit [5:1] r);
    int w;
    bit [5:1] c;
    if (m_id == 0) begin
      w = top(r);
      if (w != 0) begin
        m_id = w;
        m_t = 0;
        r[w] = 1'b0;
        m_pend |= r;
      end
    end else begin
      r[m_id] = 1'b0;
      if (m_t + 1 == lens[m_id] * P) begin
        c = m_pend | r;
        w = top(c);
        m_id = w;
        m_t = 0;
        if (w != 0) c[w] = 1'b0;
        m_pend = c;
      end else begin
        w = top(r);
        if (w != 0 && w < m_id) begin
          m_id = w;
          m_t = 0;
          r[w] = 1'b0;
        end else begin
          m_t++;
        end
        m_pend |= r;
      end
    end
  endtask

  task automatic cyc(bit [5:1] r, bit m);
    rq = r;
    mute = m;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    rq = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    rq = '0;
    mute = 1'b0;
    m_id = 0;
    m_t = 0;
    m_pend = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, curId, sndOut} !== 8'd0) begin
      failures++;
      $display("FAIL reset got=%h want=00", {busy, curId, sndOut});
    end
    resetN = 1'b1;
  endtask

  task automatic test_start();
    for (int i = 0; i < 55; i++) begin
      cyc((i == 0) ? 5'b00001 : 5'b0, 1'b0);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL start i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_preempt();
    bit [5:1] r;
    for (int i = 0; i < 30; i++) begin
      r = (i == 0) ? 5'b10000 : (i == 3) ? 5'b00100 : 5'b0;
      cyc(r, 1'b0);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL preempt i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_chain();
    bit [5:1] r;
    for (int i = 0; i < 36; i++) begin
      r = (i == 0) ? 5'b00100 : (i == 5) ? 5'b10000 : 5'b0;
      cyc(r, 1'b0);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL chain i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 90; i++) begin
      cyc((i == 0) ? 5'b11010 : 5'b0, 1'b0);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL simul i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_retrigger_mute();
    bit [5:1] r;
    for (int i = 0; i < 30; i++) begin
      r = (i == 0 || i == 5) ? 5'b01000 : 5'b0;
      cyc(r, 1'b1);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL retrig_mute i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit [5:1] r;
    for (int i = 0; i < 14; i++) begin
      r = (i == 0) ? 5'b00001 : (i == 5) ? 5'b10000 : 5'b0;
      cyc(r, 1'b0);
    end
    resetN = 1'b0;
    m_id = 0;
    m_t = 0;
    m_pend = '0;
    #1;
    checks++;
    if ({busy, curId, sndOut} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=00", {busy, curId, sndOut});
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc((i == 20) ? 5'b00100 : 5'b0, 1'b0);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL post_reset i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  task automatic test_random();
    bit [5:1] r;
    bit m;
    m = 1'b0;
    for (int i = 0; i < 900; i++) begin
      r = '0;
      if (i < 700 && $urandom_range(0, 7) == 0) r = 5'($urandom);
      if ($urandom_range(0, 15) == 0) m = ~m;
      cyc(r, m);
      checks++;
      if ({busy, curId, sndOut} !== exp_all()) begin
        failures++;
        $display("FAIL random i=%0d got=%h want=%h", i,
                 {busy, curId, sndOut}, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_preempt();
    test_chain();
    test_simul();
    test_retrigger_mute();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Schedules the single shared sound output `sndOut` between the game's sound requesters.
- Plays fixed note sequences (jingles and effects) from an internal ROM. Timing comes from clock-cycle counters, not delays.
- Arbitrates simultaneous requests by fixed priority, preempts lower-priority playback, and holds one pending slot per requester.
- Sits between the game controller and the audio tone generator; the controller only pulses one-cycle requests.

Parameters:
- NOTE_CYCLES, 5000000, clock cycles each note is held (100 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 500000, clock cycles of silence after every note; must be >= 1.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- reqStart  in  1  one-cycle pulse: start jingle, id 1
- reqEnd  in  1  one-cycle pulse: end jingle, id 2
- reqHit  in  1  one-cycle pulse: hit effect, id 3
- reqLrrr  in  1  one-cycle pulse: Lrrr effect, id 4
- reqShot  in  1  one-cycle pulse: shot effect, id 5
- mute  in  1  forces `sndOut` to 0; sequencing continues
- sndOut  out  4  note code to tone generator; 0 = silence
- busy  out  1  a sequence is playing (note or gap)
- curId  out  3  id of the playing sequence; 0 when idle

Behaviour:
- Reset is asynchronous, active-low, on resetN; clock is clk. Reset value of every output and register is 0: `sndOut`, `busy`, `curId`, pending bits, counters, note index. FSM resets to IDLE. Reset mid-sequence aborts it and discards all pending requests.
- Sequence ROM (note codes in order):
  - id1: 7,7,2,3,9,9,5,7 (8 notes)
  - id2: 9,7,5,3,2,1,1,1 (8 notes)
  - id3: 13,12,11 (3 notes)
  - id4: 14,15,14,15 (4 notes)
  - id5: 11,10 (2 notes)
- Priority: id1 > id2 > id3 > id4 > id5; a lower id number wins.
- FSM states:
  - IDLE: `busy`=0, `curId`=0, `sndOut`=0.
  - NOTE: `sndOut` = ROM[`curId`][idx] for exactly NOTE_CYCLES cycles, then goes to GAP.
  - GAP: `sndOut`=0 for exactly GAP_CYCLES cycles. Then, if idx < last, idx+1 and back to NOTE. Otherwise the sequence ends.
- Start latency:
  - A request sampled at edge k while IDLE loads its sequence at edge k. The first note appears on `sndOut` after edge k; `busy`=1 and `curId` are valid from the same cycle.
  - Several requests in the same cycle while IDLE: the highest priority starts; the others set their pending bits.
- Preemption: a request with higher priority than `curId` aborts the current sequence at that edge and restarts NOTE at idx 0 with the new id. The aborted sequence is dropped, not resumed and not re-pended.
- Non-preempting request (lower priority than `curId`): sets its pending bit.
- Request equal to `curId`: ignored; no restart and no pending bit set.
- Repeated requests for an already-pending id collapse to one pending entry.
- Sequence end (last GAP expires):
  - If any pending bit is set, the highest-priority pending id starts NOTE idx 0 at that same edge and its bit clears. There is no idle cycle; `busy` stays 1.
  - Otherwise go to IDLE.
- A request arriving on the same edge as sequence end joins arbitration with the pending bits.
- A pending bit with higher priority than `curId` cannot exist, because such a request preempts instead.
- Counters: a single cycle counter, 32-bit, reloaded on every NOTE/GAP transition and on preemption. It counts 0..N-1, and the transition fires on the edge where the count equals N-1. idx is 3 bits.
- `mute` is combinational on the output only: `sndOut` = `mute` ? 0 : internal note. `busy`, `curId` and timing are unaffected.
- Total sequence duration = len × (NOTE_CYCLES + GAP_CYCLES) cycles.

Test Plan (NOTE_CYCLES=4, GAP_CYCLES=2):
- Single start jingle: reqStart pulse while idle -> `sndOut` = 7 for 4 cycles, then 0 for 2, then 7,2,3,9,9,5,7 in the same 4/2 pattern. `busy`=1 for 48 cycles, then `busy`=0, `curId`=0.
- Preemption: reqShot, then reqHit 3 cycles later -> `sndOut` switches from 11 to 13 on the next cycle. Then 12,11 follow, 18 cycles total for hit; the shot does not resume.
- Pending and chaining: reqHit, then reqShot during the hit -> after the hit's final gap, `sndOut` = 11 on the very next cycle with `busy` held at 1; `curId` goes 3 -> 5.
- Simultaneous requests: reqShot+reqLrrr+reqEnd in one cycle while idle -> plays id2, then id4, then id5 back-to-back (48+24+12 cycles).
- Same-id retrigger and mute: reqLrrr twice 5 cycles apart -> a single 24-cycle sequence with no restart. With `mute`=1 throughout -> `sndOut` = 0 but `curId`=4 and `busy`=1 for 24 cycles.
- Reset mid-play: resetN low during note 3 of id1 with reqShot pending -> all outputs 0 immediately (asynchronous). After release, nothing plays until a new request.
